output_channel_buffer: RTL and testbench

- Downstream neighbour of the round-robin output arbiter in the router.
- Captures the flit selected by the arbiter into a small FIFO and presents it to the outgoing link with a so/ro valid-ready handshake.
- Drives empty back to the arbiter, which only grants while empty==1.

---
 rtl/router_pkg.sv | 13 +
 rtl/ocb_fifo_mem.sv | 25 ++
 rtl/output_channel_buffer.sv | 85 ++++++++
 tb/tb_output_channel_buffer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Router-wide shared constants: flit width, port direction one-hots and buffer depth.
package router_pkg;

  localparam int unsigned FLIT_W    = 64;
  localparam int unsigned OCB_DEPTH = 2;

  localparam logic [4:0] DIR_N     = 5'b00001;
  localparam logic [4:0] DIR_E     = 5'b00010;
  localparam logic [4:0] DIR_S     = 5'b00100;
  localparam logic [4:0] DIR_W     = 5'b01000;
  localparam logic [4:0] DIR_LOCAL = 5'b10000;

endpackage

// File: rtl/ocb_fifo_mem.sv
// Flit storage for the output channel buffer: synchronous write, asynchronous read.
module ocb_fifo_mem
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = FLIT_W,
  parameter int unsigned DEPTH  = OCB_DEPTH,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/output_channel_buffer.sv
// Output-side flit FIFO between the round-robin arbiter and the link (so/ro handshake).
// Optional macro OCB_OVERFLOW_DET_EN adds a sticky ovf flag for pushes dropped while full.
module output_channel_buffer
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = FLIT_W,
  parameter int unsigned DEPTH  = OCB_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              empty,
  output logic              full,
  output logic              so,
  output logic [DATA_W-1:0] data_out,
  input  logic              ro,
`ifdef OCB_OVERFLOW_DET_EN
  output logic              ovf,
`endif
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;

  // Flags come from the registered count, so a push never bypasses to the head.
  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(DEPTH));
  assign so    = !empty;
  assign push  = wr_en && !full;
  assign pop   = so && ro;

  // Storage is not reset; masking keeps the head at zero whenever nothing is valid.
  assign data_out = empty ? DATA_W'(0) : head;

  ocb_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OCB_OVERFLOW_DET_EN
  // Sticky record of any flit dropped at the full boundary.
  always_ff @(posedge clk) begin
    if (rst)              ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en && full)
      $error("output_channel_buffer: push dropped while full");
  end
`endif

endmodule

// File: tb/tb_output_channel_buffer.sv
// Randomized and directed bench for output_channel_buffer against a queue-based reference model.
module tb_output_channel_buffer;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              empty;
  logic              full;
  logic              so;
  logic [DATA_W-1:0] data_out;
  logic              ro;
  logic [CNT_W-1:0]  count;
`ifdef OCB_OVERFLOW_DET_EN
  logic              ovf;
`endif

  output_channel_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .empty    (empty),
    .full     (full),
    .so       (so),
    .data_out (data_out),
    .ro       (ro),
`ifdef OCB_OVERFLOW_DET_EN
    .ovf      (ovf),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DATA_W-1:0] model_q [$];
  bit                model_valid = 1'b0;
  bit                model_ovf   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare state, advance the model.
  task automatic step(input bit r, input bit w, input logic [DATA_W-1:0] d, input bit rdy);
    bit m_full;
    bit m_pop;
    bit m_push;
    logic [DATA_W-1:0] head;
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    ro      = rdy;
    if (model_valid) begin
      head = (model_q.size() != 0) ? model_q[0] : '0;
      check("empty", 64'(empty), 64'(model_q.size() == 0));
      check("full",  64'(full),  64'(model_q.size() == DEPTH));
      check("so",    64'(so),    64'(model_q.size() != 0));
      check("count", 64'(count), 64'(model_q.size()));
      check("data_out", data_out, head);
`ifdef OCB_OVERFLOW_DET_EN
      check("ovf", 64'(ovf), 64'(model_ovf));
`endif
    end
    if (r) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_full = (model_q.size() == DEPTH);
      m_pop  = (model_q.size() != 0) && rdy;
      m_push = w && !m_full;
      if (w && m_full) model_ovf = 1'b1;
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ro = 1'b0;

    // Reset then idle
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(3, 1'b0);

    // Single flit held under back-pressure, then popped
    step(1'b0, 1'b1, 64'hA5, 1'b0);
    idle(4, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(2, 1'b0);

    // Fill and overflow, then drain
    step(1'b0, 1'b1, 64'h1, 1'b0);
    step(1'b0, 1'b1, 64'h2, 1'b0);
    step(1'b0, 1'b1, 64'h3, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Streaming with push and pop every cycle
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 64'(i), 1'b1);
    idle(3, 1'b1);

    // Full with simultaneous push and pop: pop wins, push rejected
    step(1'b0, 1'b1, 64'h10, 1'b0);
    step(1'b0, 1'b1, 64'h11, 1'b0);
    step(1'b0, 1'b1, 64'h99, 1'b1);
    idle(3, 1'b1);

    // Reset mid-operation discards stored flits
    step(1'b0, 1'b1, 64'h20, 1'b0);
    step(1'b0, 1'b1, 64'h21, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 64'hBEEF, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
           {$urandom, $urandom}, ($urandom_range(2) != 0));
    end
    idle(3, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
